// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and default widths for the instruction-fetch stage
package fetch_pkg;

  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;

  // IDLE: nothing outstanding; REQ: outstanding, keep data; DRAIN: outstanding, drop data
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small power-of-two fetch buffer with flush clear
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = FETCH_ADDR_W + FETCH_DATA_W,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             clear_i,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_ok;

  assign pop_ok  = pop_i & ~empty_o;
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Pointer/count next state; clear wins over push and pop, pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_ok);
    end
  end

  // Storage and pointer registers; reset also zeroes storage so the head reads 0
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch: PC accept, single-outstanding imem read, decode buffer
module if_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ce_i,
  output logic              pc_stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              flush,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_inst
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e             state_q, state_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [CW-1:0]            fifo_count;
  logic [CW-1:0]            count_nxt;
  logic                     fifo_full, fifo_empty;
  logic                     push, pop, room, accept;
  logic [ADDR_W+DATA_W-1:0] fifo_head;

  // State and latched request address
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Next state: back-to-back reissue on ack+accept, flush turns an open request into DRAIN
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (accept) addr_d = pc_i;
    unique case (state_q)
      IDLE:    if (accept) state_d = REQ;
      REQ: begin
        if (imem_ack)   state_d = accept ? REQ : IDLE;
        else if (flush) state_d = DRAIN;
      end
      DRAIN:   if (imem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and handshakes; the completing request already owns a slot, so count_nxt includes it
  always_comb begin
    imem_req  = (state_q != IDLE);
    pop       = ~fifo_empty & id_ready;
    push      = (state_q == REQ) & imem_ack & ~flush;
    count_nxt = fifo_count - CW'(pop) + CW'(push);
    room      = (state_q == IDLE) ? (~fifo_full | pop) : (count_nxt < CW'(DEPTH));
    accept    = ce_i & ~flush & room & ((state_q == IDLE) | ((state_q == REQ) & imem_ack));
    pc_stall  = ce_i & ~accept;
  end

  assign imem_addr = addr_q;
  assign id_valid  = ~fifo_empty;
  assign id_pc     = fifo_head[DATA_W +: ADDR_W];
  assign id_inst   = fifo_head[DATA_W-1:0];

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i ({addr_q, imem_rdata}),
    .pop_i       (pop),
    .clear_i     (flush),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed scoreboard bench for if_fetch
module tb_if_fetch;
  import fetch_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i;
  logic        ce_i;
  logic        pc_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  int n_cmp = 0;
  int n_err = 0;
  int wait_cfg = 0;
  int wait_cnt = 0;
  logic accepted = 1'b0;
  logic found;
  fetch_entry_t exp_q[$];

  if_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .pc_i       (pc_i),
    .ce_i       (ce_i),
    .pc_stall   (pc_stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .flush      (flush),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_pc      (id_pc),
    .id_inst    (id_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_3C3C;
  endfunction

  // Memory model: each request waits wait_cfg cycles before its ack
  assign imem_ack   = imem_req && (wait_cnt == 0);
  assign imem_rdata = mem_word(imem_addr);
  always @(posedge clk) begin
    if (!imem_req || imem_ack) wait_cnt <= wait_cfg;
    else if (wait_cnt > 0)     wait_cnt <= wait_cnt - 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Negedge sample: score deliveries, apply flush/reset to the model, record accepts
  task automatic sample();
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
    end else begin
      if (id_valid && id_ready && !flush) begin
        chk("pop_has_expect", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          chk("id_pc", 64'(id_pc), 64'(exp_q[0].pc));
          chk("id_inst", 64'(id_inst), 64'(exp_q[0].inst));
          void'(exp_q.pop_front());
        end
      end
      if (flush) begin
        exp_q.delete();
      end else if (ce_i && !pc_stall) begin
        exp_q.push_back('{pc: pc_i, inst: mem_word(pc_i)});
        accepted = 1'b1;
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    if (accepted) pc_i = pc_i + 32'd4;
    accepted = 1'b0;
  endtask

  task automatic drain(input int n);
    ce_i = 1'b0;
    id_ready = 1'b1;
    repeat (n) begin sample(); advance(); end
    sample();
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_id_valid", 64'(id_valid), 64'd0);
    advance();
  endtask

  task automatic wait_ack(input string tag, input int limit);
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      sample();
      if (imem_ack) begin found = 1'b1; break; end
      advance();
    end
    chk(tag, 64'(found), 64'd1);
  endtask

  initial begin
    rst = 1'b1; ce_i = 1'b0; pc_i = '0; flush = 1'b0; id_ready = 1'b1;
    #1;
    sample();
    chk("reset_pc_stall", 64'(pc_stall), 64'd0);
    advance();
    sample();
    advance();
    rst = 1'b0;
    sample();
    chk("reset_imem_req", 64'(imem_req), 64'd0);
    chk("reset_imem_addr", 64'(imem_addr), 64'd0);
    chk("reset_id_valid", 64'(id_valid), 64'd0);
    chk("reset_id_pc", 64'(id_pc), 64'd0);
    chk("reset_id_inst", 64'(id_inst), 64'd0);
    advance();

    // zero-wait stream from pc 0
    ce_i = 1'b1; pc_i = 32'h0;
    sample();
    chk("s0_stall", 64'(pc_stall), 64'd0);
    chk("s0_req", 64'(imem_req), 64'd0);
    advance();
    sample();
    chk("s1_req", 64'(imem_req), 64'd1);
    chk("s1_addr", 64'(imem_addr), 64'h0);
    chk("s1_id_valid", 64'(id_valid), 64'd0);
    chk("s1_stall", 64'(pc_stall), 64'd0);
    advance();
    sample();
    chk("s2_id_valid", 64'(id_valid), 64'd1);
    chk("s2_id_pc", 64'(id_pc), 64'h0);
    advance();
    for (int i = 0; i < 6; i++) begin
      sample();
      chk("stream_stall", 64'(pc_stall), 64'd0);
      advance();
    end
    drain(5);

    // wait states on pc 0x10
    wait_cfg = 3;
    sample(); advance();
    ce_i = 1'b1; pc_i = 32'h10;
    sample();
    chk("ws_accept", 64'(pc_stall), 64'd0);
    advance();
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("ws_req_held", 64'(imem_req), 64'd1);
      chk("ws_addr_held", 64'(imem_addr), 64'h10);
      chk("ws_stall", 64'(pc_stall), 64'd1);
      advance();
    end
    sample();
    chk("ws_ack", 64'(imem_ack), 64'd1);
    chk("ws_next_accept", 64'(pc_stall), 64'd0);
    advance();
    ce_i = 1'b0; wait_cfg = 0;
    drain(8);

    // backpressure
    id_ready = 1'b0; ce_i = 1'b1; pc_i = 32'h40;
    for (int i = 0; i < 6; i++) begin sample(); advance(); end
    sample();
    chk("bp_queued", 64'(exp_q.size()), 64'd2);
    chk("bp_stall", 64'(pc_stall), 64'd1);
    chk("bp_no_req", 64'(imem_req), 64'd0);
    chk("bp_head_pc", 64'(id_pc), 64'h40);
    advance();
    id_ready = 1'b1;
    sample();
    chk("bp_resume", 64'(pc_stall), 64'd0);
    advance();
    for (int i = 0; i < 4; i++) begin sample(); advance(); end
    drain(5);

    // flush with a request outstanding
    wait_cfg = 5; id_ready = 1'b0;
    sample(); advance();
    ce_i = 1'b1; pc_i = 32'h1C;
    wait_ack("fl_first_ack", 12);
    advance();
    sample();
    chk("fl_req", 64'(imem_req), 64'd1);
    chk("fl_addr", 64'(imem_addr), 64'h20);
    chk("fl_id_valid", 64'(id_valid), 64'd1);
    chk("fl_head", 64'(id_pc), 64'h1C);
    chk("fl_stall", 64'(pc_stall), 64'd1);
    advance();
    flush = 1'b1;
    sample();
    chk("fl_no_ack", 64'(imem_ack), 64'd0);
    advance();
    flush = 1'b0; pc_i = 32'h100; id_ready = 1'b1; wait_cfg = 0;
    sample();
    chk("fl_id_valid_cleared", 64'(id_valid), 64'd0);
    chk("fl_drain_req", 64'(imem_req), 64'd1);
    chk("fl_drain_addr", 64'(imem_addr), 64'h20);
    chk("fl_drain_stall", 64'(pc_stall), 64'd1);
    advance();
    wait_ack("fl_drain_ack", 10);
    chk("fl_drain_ack_stall", 64'(pc_stall), 64'd1);
    advance();
    found = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sample();
      if (id_valid) begin found = 1'b1; break; end
      advance();
    end
    chk("fl_first_after_flush_seen", 64'(found), 64'd1);
    chk("fl_first_after_flush_pc", 64'(id_pc), 64'h100);
    advance();
    drain(6);

    // flush coincident with ack and pop
    id_ready = 1'b0; ce_i = 1'b1; pc_i = 32'h200;
    sample();
    chk("fc_accept", 64'(pc_stall), 64'd0);
    advance();
    wait_cfg = 2;
    sample();
    chk("fc_first_ack", 64'(imem_ack), 64'd1);
    advance();
    sample(); advance();
    sample(); advance();
    flush = 1'b1; id_ready = 1'b1;
    sample();
    chk("fc_ack", 64'(imem_ack), 64'd1);
    chk("fc_addr", 64'(imem_addr), 64'h204);
    chk("fc_id_valid", 64'(id_valid), 64'd1);
    chk("fc_no_accept", 64'(pc_stall), 64'd1);
    advance();
    flush = 1'b0; ce_i = 1'b0; wait_cfg = 0;
    sample();
    chk("fc_empty", 64'(id_valid), 64'd0);
    chk("fc_idle", 64'(imem_req), 64'd0);
    advance();
    ce_i = 1'b1; pc_i = 32'h300;
    sample();
    chk("fc_idle_accept", 64'(pc_stall), 64'd0);
    advance();
    drain(6);

    // reset mid-operation
    id_ready = 1'b0; wait_cfg = 4;
    sample(); advance();
    ce_i = 1'b1; pc_i = 32'h400;
    wait_ack("rs_setup_ack", 12);
    advance();
    sample();
    chk("rs_pre_req", 64'(imem_req), 64'd1);
    chk("rs_pre_valid", 64'(id_valid), 64'd1);
    advance();
    rst = 1'b1; ce_i = 1'b0;
    sample();
    chk("rs_pc_stall", 64'(pc_stall), 64'd0);
    advance();
    rst = 1'b0;
    sample();
    chk("rs_imem_req", 64'(imem_req), 64'd0);
    chk("rs_imem_addr", 64'(imem_addr), 64'd0);
    chk("rs_id_valid", 64'(id_valid), 64'd0);
    chk("rs_id_pc", 64'(id_pc), 64'd0);
    chk("rs_id_inst", 64'(id_inst), 64'd0);
    advance();
    id_ready = 1'b1; wait_cfg = 0; ce_i = 1'b1; pc_i = 32'h500;
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("rs_stream_stall", 64'(pc_stall), 64'd0);
      advance();
    end
    drain(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
